lstm_input_fetch: RTL and testbench

Sequential reader for the LSTM input-sample ROM. On a start pulse it walks every stored input vector in order: NUM_SEQ sequences × NUM_ITERATIONS timesteps × NUM elements per vector. It drives the ROM's combinational read address and streams each word to the LSTM forward datapath over a one-deep valid/ready output register. Each beat carries position tags, so the consumer needs no counters of its own.

---
 rtl/lstm_input_fetch.sv | 122 ++++++++++++
 tb/tb_lstm_input_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lstm_input_fetch.sv
// Sequential reader for the LSTM input-sample ROM: walks seq x step x feat in
// order and streams each word over a one-deep valid/ready register with position tags.
module lstm_input_fetch #(
  parameter int WIDTH          = 32,
  parameter int NUM            = 45,
  parameter int NUM_ITERATIONS = 8,
  parameter int NUM_SEQ        = 2,
  localparam int SW = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic [WIDTH-1:0]        addr,
  input  logic signed [WIDTH-1:0] mem_data,
  output logic signed [WIDTH-1:0] x_data,
  output logic                    x_valid,
  input  logic                    x_ready,
  output logic                    x_last_feat,
  output logic                    x_last_step,
  output logic [SW-1:0]           x_seq,
  output logic                    busy,
  output logic                    done
);

  localparam int FW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int TW = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, next_state;
  logic [FW-1:0] feat;
  logic [TW-1:0] step;
  logic [SW-1:0] seq;
  logic          load, accept;
  logic          feat_last, step_last, seq_last, final_elem;

  assign feat_last  = (feat == FW'(NUM - 1));
  assign step_last  = (step == TW'(NUM_ITERATIONS - 1));
  assign seq_last   = (seq == SW'(NUM_SEQ - 1));
  assign final_elem = feat_last && step_last && seq_last;
  assign accept     = x_valid && x_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN: begin
        load = !x_valid || x_ready;
        if (load && final_elem) next_state = DRAIN;
      end
      DRAIN:   if (accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // abort outranks start and any load in the same cycle
    if (abort) begin
      next_state = IDLE;
      load       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      feat        <= '0;
      step        <= '0;
      seq         <= '0;
      x_data      <= '0;
      x_valid     <= 1'b0;
      x_last_feat <= 1'b0;
      x_last_step <= 1'b0;
      x_seq       <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        x_valid <= 1'b0;
        addr    <= '0;
        feat    <= '0;
        step    <= '0;
        seq     <= '0;
      end else if (load) begin
        x_data      <= mem_data;
        x_valid     <= 1'b1;
        x_last_feat <= feat_last;
        x_last_step <= step_last;
        x_seq       <= seq;
        // the final load keeps addr on the last word until the beat drains
        if (!final_elem) addr <= addr + WIDTH'(1);
        if (feat_last) begin
          feat <= '0;
          if (step_last) begin
            step <= '0;
            seq  <= seq_last ? '0 : seq + SW'(1);
          end else begin
            step <= step + TW'(1);
          end
        end else begin
          feat <= feat + FW'(1);
        end
      end else if (state == DRAIN && accept) begin
        x_valid <= 1'b0;
        done    <= 1'b1;
        addr    <= '0;
        feat    <= '0;
        step    <= '0;
        seq     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lstm_input_fetch.sv
// Directed bench for lstm_input_fetch: default config plus a 3x2x2 instance,
// ROM modelled as word k = k.
module tb_lstm_input_fetch;

  localparam int N_BEATS = 45 * 8 * 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, x_ready = 1'b0;
  logic [31:0] addr;
  logic signed [31:0] mem_data, x_data;
  logic        x_valid, x_last_feat, x_last_step, busy, done;
  logic [0:0]  x_seq;

  logic        s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b0;
  logic [31:0] s_addr;
  logic signed [31:0] s_mem, s_data;
  logic        s_valid, s_last_feat, s_last_step, s_busy, s_done;
  logic [0:0]  s_seq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_data = addr;
  assign s_mem    = s_addr;

  lstm_input_fetch dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .addr(addr),
    .mem_data(mem_data), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .x_last_feat(x_last_feat), .x_last_step(x_last_step), .x_seq(x_seq),
    .busy(busy), .done(done)
  );

  lstm_input_fetch #(.WIDTH(32), .NUM(3), .NUM_ITERATIONS(2), .NUM_SEQ(2)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .addr(s_addr),
    .mem_data(s_mem), .x_data(s_data), .x_valid(s_valid), .x_ready(s_ready),
    .x_last_feat(s_last_feat), .x_last_step(s_last_step), .x_seq(s_seq),
    .busy(s_busy), .done(s_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // {last_feat, last_step, seq} expected for beat k of the default config
  function automatic logic [31:0] exp_tags(input int k);
    int f, s;
    f = k % 45;
    s = (k / 45) % 8;
    return {29'd0, f == 44, s == 7, k >= 360};
  endfunction

  // mode 0: ready high, 1: random ready, 2: stray start at beat 50, 3: stall at beat 100
  task automatic run_pass(input int mode);
    int beats = 0, cyc = 2, dones = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
    int stall = 0;
    bit stalled = 0;
    logic [31:0] hold_addr = '0;
    @(negedge clk); start = 1'b1; x_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy", {31'd0, busy}, 1);
    check("start_addr", addr, 0);
    check("start_valid", {31'd0, x_valid}, 0);
    @(negedge clk);
    check("first_valid", {31'd0, x_valid}, 1);
    while (cyc < 4000 && !(beats == N_BEATS && cyc > last_cyc + 3)) begin
      if (mode == 3 && beats == 100 && !stalled && x_valid) begin
        stall = 5; stalled = 1; hold_addr = addr;
      end
      if (stall > 0) begin
        x_ready = 1'b0;
        check("stall_data", x_data, 100);
        check("stall_tags", {29'd0, x_last_feat, x_last_step, x_seq}, exp_tags(100));
        check("stall_addr", addr, hold_addr);
        check("stall_valid", {31'd0, x_valid}, 1);
        stall--;
      end else if (mode == 1) begin
        x_ready = 1'($urandom_range(0, 1));
      end else begin
        x_ready = 1'b1;
      end
      start = (mode == 2 && beats == 50);
      if (done) begin
        dones++; done_cyc = cyc;
        check("done_busy", {31'd0, busy}, 0);
      end
      if (x_valid && x_ready) begin
        check("beat_data", x_data, beats);
        check("beat_tags", {29'd0, x_last_feat, x_last_step, x_seq}, exp_tags(beats));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    check("pass_beats", beats, N_BEATS);
    check("pass_dones", dones, 1);
    check("done_timing", done_cyc, last_cyc + 1);
    check("pass_idle", {31'd0, busy}, 0);
    if (mode == 0 || mode == 2) check("no_bubbles", last_cyc - first_cyc, N_BEATS - 1);
    if (mode == 3) check("stall_span", last_cyc - first_cyc, N_BEATS - 1 + 5);
  endtask

  initial begin
    int beats, dones;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_addr", addr, 0);
    check("rst_data", x_data, 0);
    check("rst_outs", {26'd0, x_valid, x_last_feat, x_last_step, x_seq, busy, done}, 0);

    run_pass(0);
    run_pass(3);
    run_pass(1);
    run_pass(2);

    // abort once beat 200 is at the output
    @(negedge clk); start = 1'b1; x_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 400 && !(x_valid && x_data == 200); i++) @(negedge clk);
    check("abort_reach", x_data, 200);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_valid", {31'd0, x_valid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_addr", addr, 0);
    dones = 0;
    repeat (5) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort_nodone", dones, 0);
    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_wins", {31'd0, busy}, 0);
    run_pass(0);

    // asynchronous reset mid-pass, off both clock edges
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_addr", addr, 0);
    check("arst_data", x_data, 0);
    check("arst_outs", {26'd0, x_valid, x_last_feat, x_last_step, x_seq, busy, done}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("arst_stay_idle", {30'd0, busy, x_valid}, 0);

    // small configuration: 3 features x 2 steps x 2 sequences
    s_ready = 1'b1;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    beats = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_done) dones++;
      if (s_valid && s_ready) begin
        check("s_data", s_data, beats);
        check("s_tags", {29'd0, s_last_feat, s_last_step, s_seq},
              {29'd0, beats % 3 == 2, (beats / 3) % 2 == 1, beats >= 6});
        beats++;
      end
      @(negedge clk);
    end
    check("s_beats", beats, 12);
    check("s_dones", dones, 1);
    check("s_idle", {31'd0, s_busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
